bus_arbiter: RTL and testbench

- Shares the single peripheral write bus (write/value, as driven to the LED block) among N requesters, e.g. cpu core and a debug loader.
- Round-robin arbitration; captures the winner's address/data, presents a registered write strobe to peripherals, waits for ready, then acknowledges the requester.
- A timeout aborts writes to unresponsive peripherals and flags an error.
- Sits between requesters and peripheral address decode in top.

---
 rtl/bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//
// Shares the single peripheral write bus among N requesters (e.g. the CPU core
// and a debug loader). A round-robin pointer picks one pending request, its
// address/data are captured and presented with a registered write strobe until
// the peripheral signals ready (or a timeout expires), and the winner then
// receives a one-cycle ack with an error flag telling it whether the write was
// aborted.
//
// Ports:
//   clk_i    - system clock
//   rstn_i   - asynchronous active-low reset
//   req_i    - per-requester write request, held until ack
//   addr_i   - packed addresses, requester k at [k*AW +: AW]
//   wdata_i  - packed write data, requester k at [k*DW +: DW]
//   ack_o    - one-cycle completion pulse to the granted requester
//   err_o    - valid with ack_o; 1 = write aborted by timeout
//   grant_o  - index of the current or last granted requester
//   busy_o   - high while a transfer is in flight (BUSY and ACK)
//   write_o  - peripheral write strobe
//   addr_o   - peripheral address (qualify with write_o)
//   value_o  - peripheral write data (qualify with write_o)
//   ready_i  - peripheral accepts the write this cycle
// ----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N       = 2,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15,
    localparam int GW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [N-1:0]    req_i,
    input  logic [N*AW-1:0] addr_i,
    input  logic [N*DW-1:0] wdata_i,
    output logic [N-1:0]    ack_o,
    output logic            err_o,
    output logic [GW-1:0]   grant_o,
    output logic            busy_o,
    output logic            write_o,
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   value_o,
    input  logic            ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Last BUSY cycle before the write is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e          state_q;
    logic [GW-1:0]   ptr_q;
    logic [GW-1:0]   ptr_d;
    logic [7:0]      cnt_q;
    logic [N-1:0]    ack_q;
    logic            err_q;
    logic [GW-1:0]   grant_q;
    logic            busy_q;
    logic            write_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   value_q;

    // Arbitration signals
    logic [N-1:0]    hi_mask;
    logic [N-1:0]    req_hi;
    logic [N-1:0]    req_sel;
    logic [GW-1:0]   win_idx;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   data_sel;

    // Round-robin pick: requests at or above the pointer take priority; if none
    // are pending there the search wraps to the lowest index. This is the same
    // as scanning ptr, ptr+1, ... mod N, but needs no modular arithmetic.
    // NOTE: every signal assigned in this block gets a default at the top, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        hi_mask  = '0;
        win_idx  = '0;
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr_q));
        end
        req_hi  = req_i & hi_mask;
        req_sel = (|req_hi) ? req_hi : req_i;
        // Walk downwards so the lowest set bit is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_sel[i]) begin
                win_idx = GW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (GW'(i) == win_idx) begin
                addr_sel = addr_i[i*AW +: AW];
                data_sel = wdata_i[i*DW +: DW];
            end
        end
    end

    // Pointer moves just past the requester that was served.
    always_comb begin
        if (int'(grant_q) == N - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_q + 1'b1;
        end
    end

    // Control FSM with all outputs registered.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        addr_q  <= addr_sel;
                        value_q <= data_sel;
                        grant_q <= win_idx;
                        write_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // Ready is checked first so a late ready in the final
                    // cycle still completes the write without error.
                    if (ready_i || (cnt_q == CNT_LAST)) begin
                        write_q <= 1'b0;
                        ack_q   <= N'(1) << grant_q;
                        err_q   <= ~ready_i;
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                ST_ACK: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign grant_o = grant_q;
    assign busy_o  = busy_q;
    assign write_o = write_q;
    assign addr_o  = addr_q;
    assign value_o = value_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter (N=2, AW=8, DW=32, TIMEOUT=15).
// A transaction-level reference model predicts each transfer: the winner is
// the first requester at or after the model pointer (mod N), the strobe stays
// high for min(ready_delay+1, TIMEOUT) cycles, and the error flag is set when
// ready never arrives inside that window.
// ----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int N       = 2;
    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;
    localparam int GW      = 1;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic [N-1:0]    req_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    ack_o;
    logic            err_o;
    logic [GW-1:0]   grant_o;
    logic            busy_o;
    logic            write_o;
    logic [AW-1:0]   addr_o;
    logic [DW-1:0]   value_o;
    logic            ready_i;

    int n_checks = 0;
    int n_pass   = 0;
    int ptr_m    = 0;   // model round-robin pointer

    bus_arbiter #(
        .N      (N),
        .AW     (AW),
        .DW     (DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_i  (req_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .grant_o(grant_o),
        .busy_o (busy_o),
        .write_o(write_o),
        .addr_o (addr_o),
        .value_o(value_o),
        .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First pending requester scanning ptr, ptr+1, ... mod N.
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   64'(ack_o),   64'd0);
        check({tag, "_err"},   64'(err_o),   64'd0);
        check({tag, "_grant"}, 64'(grant_o), 64'd0);
        check({tag, "_busy"},  64'(busy_o),  64'd0);
        check({tag, "_write"}, 64'(write_o), 64'd0);
        check({tag, "_addr"},  64'(addr_o),  64'd0);
        check({tag, "_value"}, 64'(value_o), 64'd0);
    endtask

    // One complete transfer. Entered and left at posedge+1 with the DUT idle.
    // rdy_dly: number of BUSY cycles with ready low before ready rises.
    // drop_mid: drop req and scramble inputs while the transfer is in flight.
    task automatic xfer(input logic [N-1:0] req, input int rdy_dly,
                        input bit drop_mid, input bit rand_data);
        int            win;
        int            hi;
        int            exp_hi;
        bit            exp_err;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;

        if (rand_data) begin
            for (int k = 0; k < N; k++) begin
                addr_i[k*AW +: AW]  = AW'($urandom);
                wdata_i[k*DW +: DW] = $urandom;
            end
        end
        win     = pick(req, ptr_m);
        ea      = addr_i[win*AW +: AW];
        ed      = wdata_i[win*DW +: DW];
        exp_hi  = (rdy_dly + 1 < TIMEOUT) ? rdy_dly + 1 : TIMEOUT;
        exp_err = (rdy_dly >= TIMEOUT);

        req_i   = req;
        ready_i = (rdy_dly == 0);
        @(posedge clk_i); #1;
        check("write_cycle1", 64'(write_o), 64'd1);
        check("grant",        64'(grant_o), 64'(win));
        check("addr_o",       64'(addr_o),  64'(ea));
        check("value_o",      64'(value_o), 64'(ed));
        check("busy_xfer",    64'(busy_o),  64'd1);
        check("ack_idle",     64'(ack_o),   64'd0);

        if (drop_mid) begin
            req_i   = '0;
            addr_i  = (N*AW)'($urandom);
            wdata_i = {$urandom, $urandom};
        end

        hi = 0;
        for (int k = 0; k < TIMEOUT + 2; k++) begin
            if (write_o !== 1'b1) break;
            hi++;
            check("hold_addr",  64'(addr_o),  64'(ea));
            check("hold_value", 64'(value_o), 64'(ed));
            ready_i = (k >= rdy_dly);
            @(posedge clk_i); #1;
        end

        // Now in the ACK cycle.
        check("write_len", 64'(hi),     64'(exp_hi));
        check("ack_onehot", 64'(ack_o), 64'(1) << win);
        check("err",       64'(err_o),  64'(exp_err));
        check("busy_ack",  64'(busy_o), 64'd1);
        ready_i = 1'b0;
        req_i   = '0;
        @(posedge clk_i); #1;
        check("ack_clear",  64'(ack_o),   64'd0);
        check("err_clear",  64'(err_o),   64'd0);
        check("busy_clear", 64'(busy_o),  64'd0);
        check("write_idle", 64'(write_o), 64'd0);
        check("grant_hold", 64'(grant_o), 64'(win));
        check("addr_keep",  64'(addr_o),  64'(ea));
        ptr_m = (win + 1) % N;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] rq;
        rstn_i  = 1'b0;
        req_i   = '0;
        ready_i = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // Reset asserted in the middle of a stalled transfer.
        addr_i  = {8'hA5, 8'h3C};
        wdata_i = {32'h1234_5678, 32'hCAFE_F00D};
        req_i   = 2'b01;
        @(posedge clk_i); #1;
        check("rst_pre_write", 64'(write_o), 64'd1);
        repeat (3) @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        req_i  = '0;
        #1;
        check_all_zero("midrst");
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("post_rst_write", 64'(write_o), 64'd0);
        check("post_rst_busy",  64'(busy_o),  64'd0);
        ptr_m = 0;

        // Round-robin: both request every transfer, grants alternate 0,1,0,1.
        for (int t = 0; t < 4; t++) begin
            xfer(2'b11, 0, 1'b0, 1'b1);
            check("rr_grant_seq", 64'(grant_o), 64'(t % 2));
        end

        // Single write with known data.
        addr_i  = {8'h55, 8'h10};
        wdata_i = {32'hDEAD_BEEF, 32'h0000_002A};
        xfer(2'b01, 0, 1'b0, 1'b0);

        // Ready stall of 5 cycles -> strobe high for 6.
        xfer(2'b01, 5, 1'b0, 1'b1);

        // Timeout, then the other requester wins the next contest.
        xfer(2'b01, 100, 1'b0, 1'b1);
        xfer(2'b11, 0, 1'b0, 1'b1);
        check("after_timeout_grant", 64'(grant_o), 64'd1);

        // Ready arrives in the very last allowed cycle: no error.
        xfer(2'b10, TIMEOUT - 1, 1'b0, 1'b1);

        // Request dropped during BUSY: transfer still completes.
        xfer(2'b11, 3, 1'b1, 1'b1);

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            rq = N'($urandom_range(1, (1 << N) - 1));
            xfer(rq, int'($urandom_range(0, TIMEOUT + 3)), 1'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
